// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
// State encoding, parity-mode constants and the 3-sample majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } uart_rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through frame buffer.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign overrun = push && !do_push;

    assign valid = !empty;
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, bit timing, frame FSM and flag
// generation, feeding completed frames into a small FWFT buffer.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 576000,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [PAYLOAD_BITS-1:0] rx_data,
    output logic                    rx_parity_err,
    output logic                    rx_frame_err,
    output logic                    rx_break,
    output logic                    rx_overrun,
    output logic                    rx_busy
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int H   = CPB / 2;
    localparam int CW  = $clog2(CPB);
    localparam int EW  = PAYLOAD_BITS + 3;

    uart_rx_state_e          state;
    uart_rx_state_e          state_nxt;
    logic                    sync1;
    logic                    sync2;
    logic [CW-1:0]           cnt;
    logic [3:0]              bit_idx;
    logic                    smp_a;
    logic                    smp_b;
    logic                    maj;
    logic [PAYLOAD_BITS-1:0] data_sr;
    logic                    pbit;
    logic                    frame_err;
    logic                    stop_err;
    logic                    par_err;
    logic                    brk;
    logic                    push;
    logic                    at_s0;
    logic                    at_s1;
    logic                    at_mid;
    logic                    at_end;

    // Line synchroniser; frozen while reception is disabled.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else if (uart_rx_en) begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
        end
    end

    assign at_s0  = (cnt == CW'(H - 1));
    assign at_s1  = (cnt == CW'(H));
    assign at_mid = (cnt == CW'(H + 1));
    assign at_end = (cnt == CW'(CPB - 1));
    assign maj    = majority3(smp_a, smp_b, sync2);

    assign stop_err = frame_err | ~maj;
    assign par_err  = (PARITY != PARITY_NONE) && ((^data_sr ^ pbit) != (PARITY == PARITY_ODD));
    assign brk      = stop_err && (data_sr == '0) && ((PARITY == PARITY_NONE) || !pbit);

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        if (!uart_rx_en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (!sync2) state_nxt = ST_START;
                ST_START: begin
                    if (at_mid && maj) state_nxt = ST_IDLE;
                    else if (at_end)   state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    if (at_end && bit_idx == 4'(PAYLOAD_BITS - 1))
                        state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end
                ST_PARITY:   if (at_end) state_nxt = ST_STOP;
                ST_STOP: begin
                    // The frame is committed mid-way through the last stop bit so the
                    // receiver is already idle when the next start edge can arrive.
                    if (at_mid && bit_idx == 4'(STOP_BITS - 1)) begin
                        push      = 1'b1;
                        state_nxt = stop_err ? ST_BRK_WAIT : ST_IDLE;
                    end
                end
                ST_BRK_WAIT: if (sync2) state_nxt = ST_IDLE;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt       <= '0;
            bit_idx   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (state == ST_IDLE || state == ST_BRK_WAIT || at_end) cnt <= '0;
            else                                                     cnt <= cnt + CW'(1);

            if (state != state_nxt)
                bit_idx <= '0;
            else if (at_end && (state == ST_DATA || state == ST_STOP))
                bit_idx <= bit_idx + 4'(1);

            if (state == ST_IDLE)                       frame_err <= 1'b0;
            else if (state == ST_STOP && at_mid && !maj) frame_err <= 1'b1;
        end
    end

    // Sample capture and payload shift register.
    always_ff @(posedge clk) begin
        if (at_s0) smp_a <= sync2;
        if (at_s1) smp_b <= sync2;
        if (state == ST_DATA && at_mid) data_sr <= {maj, data_sr[PAYLOAD_BITS-1:1]};
        if (state == ST_IDLE)                pbit <= 1'b0;
        else if (state == ST_PARITY && at_mid) pbit <= maj;
    end

    logic [EW-1:0] head;

    uart_rx_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data ({brk, stop_err, par_err, data_sr}),
        .pop       (rx_ready),
        .valid     (rx_valid),
        .head      (head),
        .overrun   (rx_overrun)
    );

    assign {rx_break, rx_frame_err, rx_parity_err, rx_data} = head;
    assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised and directed bench for uart_rx_cfg: an 8N1 and an 8E1 receiver,
// each checked against a queue of frames predicted from the transmitted bits.
module tb_uart_rx_cfg;
    localparam int CPB = 50_000_000 / 576000;

    logic clk = 1'b0;
    logic resetn, rx_en, rx_ready;
    logic rxd_n, rxd_e;
    logic v_n, pe_n, fe_n, brk_n, ovr_n, busy_n;
    logic v_e, pe_e, fe_e, brk_e, ovr_e, busy_e;
    logic [7:0] d_n, d_e;

    int n_cmp = 0;
    int n_mis = 0;
    int pops_n = 0, pops_e = 0;
    int ovr_cnt_n = 0, ovr_cnt_e = 0;
    int ovr_exp_n = 0, ovr_exp_e = 0;
    logic [10:0] exp_n[$];
    logic [10:0] exp_e[$];

    always #10 clk = ~clk;

    uart_rx_cfg #(.PARITY(0)) u_n (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd_n), .uart_rx_en(rx_en),
        .rx_valid(v_n), .rx_ready(rx_ready), .rx_data(d_n), .rx_parity_err(pe_n),
        .rx_frame_err(fe_n), .rx_break(brk_n), .rx_overrun(ovr_n), .rx_busy(busy_n)
    );

    uart_rx_cfg #(.PARITY(1)) u_e (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd_e), .uart_rx_en(rx_en),
        .rx_valid(v_e), .rx_ready(rx_ready), .rx_data(d_e), .rx_parity_err(pe_e),
        .rx_frame_err(fe_e), .rx_break(brk_e), .rx_overrun(ovr_e), .rx_busy(busy_e)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Consumer side: every accepted head must match the oldest predicted frame.
    always @(negedge clk) begin
        if (resetn) begin
            if (v_n && rx_ready) begin
                if (exp_n.size() == 0) chk("n_spurious_entry", 1, 0);
                else chk("n_entry", {21'd0, brk_n, fe_n, pe_n, d_n}, {21'd0, exp_n.pop_front()});
                pops_n++;
            end
            if (v_e && rx_ready) begin
                if (exp_e.size() == 0) chk("e_spurious_entry", 1, 0);
                else chk("e_entry", {21'd0, brk_e, fe_e, pe_e, d_e}, {21'd0, exp_e.pop_front()});
                pops_e++;
            end
            if (ovr_n) ovr_cnt_n++;
            if (ovr_e) ovr_cnt_e++;
        end
    end

    task automatic set_line(input int sel, input logic b);
        if (sel == 0) rxd_n = b;
        else          rxd_e = b;
    endtask

    // Hold one bit; optionally flip the line for a single cycle somewhere inside it.
    task automatic hold_bit(input int sel, input logic b, input logic glitch);
        int pos;
        set_line(sel, b);
        if (glitch) begin
            pos = $urandom_range(CPB - 2, 1);
            repeat (pos) @(negedge clk);
            set_line(sel, ~b);
            @(negedge clk);
            set_line(sel, b);
            repeat (CPB - pos - 1) @(negedge clk);
        end else begin
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic pbit_ok,
                        input logic stop0, input logic glitch);
        logic        pb;
        logic [10:0] e;
        pb = (^d) ^ ~pbit_ok;
        e  = {stop0 && d == 8'h00 && (sel == 0 || !pb), stop0, (sel != 0) && !pbit_ok, d};
        if (sel == 0) begin
            if (exp_n.size() < 4) exp_n.push_back(e);
            else                  ovr_exp_n++;
        end else begin
            if (exp_e.size() < 4) exp_e.push_back(e);
            else                  ovr_exp_e++;
        end
        hold_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(sel, d[i], glitch && ($urandom_range(1, 0) == 1));
        if (sel != 0) hold_bit(sel, pb, glitch && ($urandom_range(1, 0) == 1));
        hold_bit(sel, ~stop0, 1'b0);
        set_line(sel, 1'b1);
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Frame of zeros interrupted in data bit 3 by reset or by dropping the enable.
    task automatic abort_frame(input logic use_reset, input string tag);
        hold_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) hold_bit(0, 1'b0, 1'b0);
        repeat (CPB / 2) @(negedge clk);
        if (use_reset) resetn = 1'b0;
        else           rx_en  = 1'b0;
        repeat (CPB / 2 + 5 * CPB) @(negedge clk);
        rxd_n = 1'b1;
        repeat (5) @(negedge clk);
        chk({tag, "_busy"}, busy_n, 0);
        chk({tag, "_valid"}, v_n, 0);
        resetn = 1'b1;
        rx_en  = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send(0, 8'h5A, 1'b1, 1'b0, 1'b0);
        chk({tag, "_queue_left"}, exp_n.size(), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int first_low;
        logic [7:0] rd;
        resetn = 1'b0; rx_en = 1'b1; rx_ready = 1'b1; rxd_n = 1'b1; rxd_e = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_valid_n", v_n, 0);
        chk("rst_flags_n", {ovr_n, brk_n, fe_n, pe_n, d_n}, 0);
        chk("rst_busy_n", busy_n, 0);
        chk("rst_valid_e", v_e, 0);
        chk("rst_flags_e", {ovr_e, brk_e, fe_e, pe_e, d_e}, 0);
        chk("rst_busy_e", busy_e, 0);
        resetn = 1'b1;
        repeat (3 * CPB) @(negedge clk);

        p0 = pops_n;
        send(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        chk("a5_one_entry", pops_n - p0, 1);

        p0 = pops_e;
        send(1, 8'h07, 1'b0, 1'b0, 1'b0);
        send(1, 8'h07, 1'b1, 1'b0, 1'b0);
        chk("e07_two_entries", pops_e - p0, 2);

        // Short low pulse: a false start must be rejected without an entry.
        p0 = pops_n;
        rxd_n = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_busy_high", busy_n, 1);
        rxd_n = 1'b1;
        first_low = 0;
        for (int k = 21; k <= 80; k++) begin
            @(negedge clk);
            if (!busy_n && first_low == 0) first_low = k;
        end
        chk("glitch_busy_drop", (first_low >= 40 && first_low <= 48), 1);
        repeat (CPB) @(negedge clk);
        chk("glitch_no_entry", pops_n - p0, 0);

        // Held-low line: one break entry, then silence until the line recovers.
        p0 = pops_n;
        exp_n.push_back({1'b1, 1'b1, 1'b0, 8'h00});
        rxd_n = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        chk("break_one_entry", pops_n - p0, 1);
        chk("break_wait_busy", busy_n, 1);
        rxd_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send(0, 8'h3C, 1'b1, 1'b0, 1'b0);
        chk("after_break_entries", pops_n - p0, 2);

        // Fill the buffer with the consumer stalled.
        p0 = ovr_cnt_n;
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b1, 1'b0, 1'b0);
        chk("ovr_pulses", ovr_cnt_n - p0, 1);
        chk("ovr_valid_held", v_n, 1);
        chk("ovr_head_first", d_n, 8'h01);
        p0 = pops_n;
        rx_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("drain_count", pops_n - p0, 4);
        chk("drain_valid_low", v_n, 0);

        abort_frame(1'b1, "abort_rst");
        abort_frame(1'b0, "abort_en");

        // Random frames on both receivers, with occasional parity/stop errors and glitches.
        for (int i = 0; i < 12; i++) begin
            rd = 8'($urandom);
            if ($urandom_range(7, 0) == 0) rd = 8'h00;
            send($urandom_range(1, 0), rd, $urandom_range(3, 0) != 0,
                 $urandom_range(5, 0) == 0, 1'b1);
        end

        chk("final_queue_n", exp_n.size(), 0);
        chk("final_queue_e", exp_e.size(), 0);
        chk("final_ovr_n", ovr_cnt_n, ovr_exp_n);
        chk("final_ovr_e", ovr_cnt_e, ovr_exp_e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
